// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Default 640x480 timing constants, derived totals and sync windows, and the
//   decode bundle that travels down the sync/blanking delay line.
//   No ports (package).
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 32;

  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  localparam int DECODE_W = 5;

  // One decoded counter position; all-zero is the inactive (blanking) decode.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic fs;
    logic ls;
  } decode_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   Enable-gated shift register of DEPTH stages; DEPTH=0 is a wire.
//   clk   : clock
//   rst   : synchronous reset, active-high, clears every stage
//   en    : shift enable
//   d     : input word (WIDTH bits)
//   q     : word delayed by DEPTH enabled cycles
module vga_delay_line #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] stages;

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the previous stage's old value in the same edge.
      // NOTE: the stages are reset (not left as plain storage) because their
      // contents drive sync outputs directly; stale bits would glitch syncs.
      always_ff @(posedge clk) begin
        if (rst) begin
          stages <= '0;
        end else if (en) begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Decodes raw h/v counter values into VGA sync/blanking, issues framebuffer
//   reads, and delays sync/blanking by 1+MEM_LAT enabled cycles so they line up
//   with the returned pixel data.
//   clk, rst        : clock, synchronous active-high reset
//   en              : pixel-clock enable
//   h_count/v_count : raw counter values (16 bits)
//   rd_en, rd_addr  : framebuffer read strobe and linear address y*H_ACTIVE+x
//   hsync, vsync    : sync outputs at configured polarity, data-aligned
//   video_on        : returned pixel is displayable
//   frame_start     : pulse with pixel (0,0) on video_on
//   line_start      : pulse with x=0 of each active line
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int MEM_LAT  = 2,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [15:0]       h_count,
  input  logic [15:0]       v_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              frame_start,
  output logic              line_start
);

  localparam logic [15:0] H_ACT_C   = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_C   = 16'(V_ACTIVE);
  localparam logic [15:0] H_TOT_C   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOT_C   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] HS_BEG_C  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END_C  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG_C  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END_C  = 16'(V_ACTIVE + V_FP + V_SYNC);

  decode_t             dec;
  decode_t             dec_q;
  decode_t             dec_out;
  logic                in_frame;
  logic [ADDR_W-1:0]   next_addr;
  logic [DECODE_W-1:0] dl_q;

  // Decode. Counts outside the frame are forced to blanking.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    dec      = '0;
    in_frame = (h_count < H_TOT_C) && (v_count < V_TOT_C);
    dec.active = (h_count < H_ACT_C) && (v_count < V_ACT_C);
    dec.hs     = in_frame && (h_count >= HS_BEG_C) && (h_count < HS_END_C);
    dec.vs     = in_frame && (v_count >= VS_BEG_C) && (v_count < VS_END_C);
    dec.fs     = (h_count == 16'd0) && (v_count == 16'd0);
    dec.ls     = (h_count == 16'd0) && (v_count < V_ACT_C);
  end

  // Address generator walks the active area in raster order with an
  // incrementing pointer instead of computing y*H_ACTIVE+x. The pointer is
  // re-anchored only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      next_addr <= '0;
      dec_q     <= '0;
    end else if (en) begin
      rd_en <= dec.active;
      dec_q <= dec;
      if (dec.active) begin
        if (dec.fs) begin
          rd_addr   <= '0;
          next_addr <= ADDR_W'(1);
        end else begin
          rd_addr   <= next_addr;
          next_addr <= next_addr + ADDR_W'(1);
        end
      end
    end
  end

  vga_delay_line #(
    .WIDTH (DECODE_W),
    .DEPTH (MEM_LAT)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (dec_q),
    .q   (dl_q)
  );

  assign dec_out     = decode_t'(dl_q);
  assign hsync       = dec_out.hs ? HS_POL : ~HS_POL;
  assign vsync       = dec_out.vs ? VS_POL : ~VS_POL;
  assign video_on    = dec_out.active;
  assign frame_start = dec_out.fs;
  assign line_start  = dec_out.ls;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing decoder and framebuffer read-address generator that sits directly downstream of the horizontal/vertical counter pair. It consumes the raw `h_count`/`v_count` values and produces VGA `hsync`, `vsync` and `video_on`, plus a framebuffer read request (`rd_en`, `rd_addr`). The sync and blanking outputs are delayed so they line up with pixel data returned by a fixed-latency framebuffer read.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels (H total = 800)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 32: vertical back porch, in lines (V total = 524, matching the vertical counter frame)
- `HS_POL`, 0: hsync asserted level (0 = active-low)
- `VS_POL`, 0: vsync asserted level (0 = active-low)
- `MEM_LAT`, 2: framebuffer read latency in `en` cycles; range 0..7
- `ADDR_W`, 19: read address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE
- `clk` in 1: system clock
- `rst` in 1: synchronous reset, active-high
- `en` in 1: pixel-clock enable; all state advances only when `en`=1
- `h_count` in 16: horizontal counter value
- `v_count` in 16: vertical counter value
- `rd_en` out 1: framebuffer read strobe; high for active pixels
- `rd_addr` out ADDR_W: linear framebuffer address, y·H_ACTIVE + x
- `hsync` out 1: horizontal sync, aligned to returned pixel data
- `vsync` out 1: vertical sync, aligned to returned pixel data
- `video_on` out 1: returned pixel data is valid to display
- `frame_start` out 1: one-`en`-cycle pulse, aligned with pixel (0,0) on `video_on`
- `line_start` out 1: one-`en`-cycle pulse, aligned with x=0 of each active line

## Operation
- Decode stage (combinational from inputs):
  - active = h < H_ACTIVE && v < V_ACTIVE
  - hs_int = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs_int = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC
  - fs_int = (h==0 && v==0)
  - ls_int = (h==0 && v < V_ACTIVE)
- Out-of-range counts (h ≥ H total or v ≥ V total) decode as blanking: active=0, syncs deasserted. No error is flagged.
- Address generator, no multiplier; internal `next_addr` register:
  - active && fs_int: rd_addr←0, next_addr←1
  - active && !fs_int: rd_addr←next_addr, next_addr←next_addr+1
  - not active: rd_addr holds, rd_en←0
  - Addition is modulo 2^ADDR_W. The last pixel (H_ACTIVE-1, V_ACTIVE-1) yields H_ACTIVE·V_ACTIVE-1.
- Delay line: {hs_int, vs_int, active, fs_int, ls_int} are registered once, then shifted through MEM_LAT further stages (advancing only on `en`) before driving the outputs. hsync/vsync output = asserted level when the delayed bit is 1, otherwise the inverted level.
- en=0: every register, including rd_en and the pulses, holds its value. A pulse seen during a stall therefore persists until the next `en`.

## Timing
- rd_en/rd_addr: 1 `en` cycle after the counts are presented.
- hsync, vsync, video_on, frame_start, line_start: 1+MEM_LAT `en` cycles after the counts. MEM_LAT=0 gives a latency of 1.
- Reset values: rd_en=0, rd_addr=0, next_addr=0, video_on=0, frame_start=0, line_start=0, hsync=~HS_POL, vsync=~VS_POL. All delay stages are cleared to the inactive decode.
- Reset mid-frame: outputs are inactive on the cycle after `rst`. After release, the address resumes correctly only from the next fs_int; until then next_addr counts from 0. Behaviour in that window is defined exactly as stated and is not an error.
- Reset has priority over `en`.
- Simultaneous fs_int and ls_int: both pulses are emitted on the same cycle.

## Structure
- Package `vga_timing_pkg`: default timing constants, derived H_TOTAL/V_TOTAL, sync start/end localparams, and the decode-bundle width (5).
- Sub-module `vga_delay_line` (params WIDTH, DEPTH; ports clk, rst, en, d, q) implements the MEM_LAT shift register. DEPTH=0 is a pass-through.
- Top: decode logic, address generator, one output register stage, and one `vga_delay_line` instance.

## Test plan
- Reset: hold rst 3 cycles with arbitrary counts → rd_en=0, rd_addr=0, hsync=1, vsync=1, video_on=0, both pulses 0.
- Drive (0,0) then (1,0), en=1 → next cycle rd_en=1 and rd_addr=0, then rd_addr=1. video_on=1 and frame_start=1 three cycles after (0,0) (MEM_LAT=2). line_start=1 with frame_start.
- Line edge: (639,5) → rd_addr=5·640+639=3839. (640,5) → rd_en=0 and rd_addr holds 3839. hsync low exactly for h=656..751, delayed by 3.
- Full frame sweep with a real counter pair → last address 307199. vsync low only for v=490..491. Next frame (0,0) restarts at 0. Count ≥800/524 injected → blanking.
- en toggling 1-0-0-1 mid-line → outputs frozen during en=0. The address sequence has no gaps or duplicates.
- MEM_LAT=0 build → syncs and video_on are 1 cycle after the counts, coincident with rd_en.
